// File: rtl/seq_sort4_compare_pkg.sv
// Shared constants for the streaming 4-element sorter.
package seq_sort4_compare_pkg;

  localparam int unsigned FRAME_LEN = 4;
  localparam int unsigned PHASE_W   = 2;

  // Sample vector at the default width; the datapath itself is parameterised on DW.
  localparam int unsigned DEFAULT_DW = 3;
  typedef logic [DEFAULT_DW-1:0] sample_t;

endpackage

// File: rtl/cmp_swap.sv
// Compare-and-swap cell: routes the smaller operand to lo and the larger to hi (unsigned).
module cmp_swap #(
  parameter int unsigned DW = 3
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] lo,
  output logic [DW-1:0] hi
);

  logic a_gt_b;

  always_comb begin
    a_gt_b = (a > b);
    lo     = a_gt_b ? b : a;
    hi     = a_gt_b ? a : b;
  end

endmodule

// File: rtl/seq_sort4_compare.sv
// Double-buffered streaming sorter: captures frames of four samples and replays each one
// in ascending order during the following frame.
module seq_sort4_compare
  import seq_sort4_compare_pkg::*;
#(
  parameter int unsigned DW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] inp,
  output logic [DW-1:0] outp
);

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [DW-1:0]      cap_q  [FRAME_LEN-1];
  logic [DW-1:0]      cap_d  [FRAME_LEN-1];
  logic [DW-1:0]      obuf_q [FRAME_LEN];
  logic [DW-1:0]      obuf_d [FRAME_LEN];
  logic [DW-1:0]      outp_q, outp_d;

  logic [DW-1:0] net_in  [FRAME_LEN];
  logic [DW-1:0] st1     [FRAME_LEN];
  logic [DW-1:0] st2     [FRAME_LEN];
  logic [DW-1:0] sorted  [FRAME_LEN];
  logic          last_ph;

  // The fourth element bypasses the capture buffer so the frame sorts on its final cycle.
  always_comb begin
    for (int i = 0; i < FRAME_LEN - 1; i++) begin
      net_in[i] = cap_q[i];
    end
    net_in[FRAME_LEN-1] = inp;
  end

  cmp_swap #(.DW(DW)) u_s1_01 (.a(net_in[0]), .b(net_in[1]), .lo(st1[0]), .hi(st1[1]));
  cmp_swap #(.DW(DW)) u_s1_23 (.a(net_in[2]), .b(net_in[3]), .lo(st1[2]), .hi(st1[3]));
  cmp_swap #(.DW(DW)) u_s2_02 (.a(st1[0]),    .b(st1[2]),    .lo(st2[0]), .hi(st2[2]));
  cmp_swap #(.DW(DW)) u_s2_13 (.a(st1[1]),    .b(st1[3]),    .lo(st2[1]), .hi(st2[3]));
  cmp_swap #(.DW(DW)) u_s3_12 (.a(st2[1]),    .b(st2[2]),    .lo(sorted[1]), .hi(sorted[2]));

  assign sorted[0] = st2[0];
  assign sorted[3] = st2[3];

  always_comb begin
    last_ph = (phase_q == PHASE_W'(FRAME_LEN - 1));
    phase_d = phase_q + PHASE_W'(1);

    for (int i = 0; i < FRAME_LEN - 1; i++) begin
      cap_d[i] = cap_q[i];
      if (phase_q == PHASE_W'(i)) begin
        cap_d[i] = inp;
      end
    end

    for (int i = 0; i < FRAME_LEN; i++) begin
      obuf_d[i] = last_ph ? sorted[i] : obuf_q[i];
    end

    // Reads the pre-edge buffer, so the last element of the old frame still gets out.
    outp_d = obuf_q[phase_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
      for (int i = 0; i < FRAME_LEN - 1; i++) begin
        cap_q[i] <= '0;
      end
      for (int i = 0; i < FRAME_LEN; i++) begin
        obuf_q[i] <= '0;
      end
      outp_q <= '0;
    end else begin
      phase_q <= phase_d;
      for (int i = 0; i < FRAME_LEN - 1; i++) begin
        cap_q[i] <= cap_d[i];
      end
      for (int i = 0; i < FRAME_LEN; i++) begin
        obuf_q[i] <= obuf_d[i];
      end
      outp_q <= outp_d;
    end
  end

  assign outp = outp_q;

endmodule

// File: tb/tb_seq_sort4_compare.sv
// Directed self-checking bench for the streaming 4-element sorter.
module tb_seq_sort4_compare;

  localparam int DW = 3;

  logic          clk;
  logic          rst;
  logic [DW-1:0] inp;
  logic [DW-1:0] outp;

  int total;
  int bad;

  seq_sort4_compare #(.DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .inp (inp),
    .outp(outp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one sample, let one edge pass, and return outp as seen just after that edge.
  task automatic drive(input logic [DW-1:0] v, output logic [DW-1:0] o);
    inp = v;
    @(posedge clk);
    #1;
    o = outp;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    inp = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [DW-1:0] o;
    logic [DW-1:0] vals [4];
    vals = '{3'd5, 3'd2, 3'd7, 3'd1};
    do_reset();
    total++;
    if (outp !== 3'd0) begin
      bad++;
      $display("FAIL reset_outp: got %0d want 0", outp);
    end
    for (int i = 0; i < 4; i++) begin
      drive(vals[i], o);
      total++;
      if (o !== 3'd0) begin
        bad++;
        $display("FAIL reset_first_frame[%0d]: got %0d want 0", i, o);
      end
    end
  endtask

  // Continues from test_reset: the frame 5,2,7,1 is now in the output buffer.
  task automatic test_basic_sort();
    logic [DW-1:0] o;
    logic [DW-1:0] exp_v [4];
    exp_v = '{3'd1, 3'd2, 3'd5, 3'd7};
    for (int i = 0; i < 4; i++) begin
      drive(3'(i + 3), o);
      total++;
      if (o !== exp_v[i]) begin
        bad++;
        $display("FAIL basic_sort[%0d]: got %0d want %0d", i, o, exp_v[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] o;
    logic [DW-1:0] in_v  [12];
    logic [DW-1:0] exp_v [12];
    in_v  = '{3'd6, 3'd6, 3'd0, 3'd4, 3'd7, 3'd3, 3'd3, 3'd1, 3'd2, 3'd5, 3'd0, 3'd6};
    exp_v = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd4, 3'd6, 3'd6, 3'd1, 3'd3, 3'd3, 3'd7};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(in_v[i], o);
      total++;
      if (o !== exp_v[i]) begin
        bad++;
        $display("FAIL back_to_back[%0d]: got %0d want %0d", i, o, exp_v[i]);
      end
    end
  endtask

  task automatic test_patterns();
    logic [DW-1:0] o;
    logic [DW-1:0] in_v  [20];
    logic [DW-1:0] exp_v [20];
    in_v  = '{3'd0, 3'd1, 3'd2, 3'd3,  3'd7, 3'd6, 3'd5, 3'd4,  3'd7, 3'd7, 3'd7, 3'd7,
              3'd0, 3'd7, 3'd0, 3'd7,  3'd3, 3'd3, 3'd3, 3'd3};
    exp_v = '{3'd0, 3'd0, 3'd0, 3'd0,  3'd0, 3'd1, 3'd2, 3'd3,  3'd4, 3'd5, 3'd6, 3'd7,
              3'd7, 3'd7, 3'd7, 3'd7,  3'd0, 3'd0, 3'd7, 3'd7};
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(in_v[i], o);
      total++;
      if (o !== exp_v[i]) begin
        bad++;
        $display("FAIL patterns[%0d]: got %0d want %0d", i, o, exp_v[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [DW-1:0] o;
    logic [DW-1:0] in_v  [8];
    logic [DW-1:0] exp_v [8];
    in_v  = '{3'd4, 3'd1, 3'd6, 3'd2, 3'd7, 3'd7, 3'd0, 3'd0};
    exp_v = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd4, 3'd6};
    do_reset();
    drive(3'd3, o);
    drive(3'd5, o);
    rst = 1'b1;
    inp = 3'd7;
    @(posedge clk);
    #1;
    rst = 1'b0;
    total++;
    if (outp !== 3'd0) begin
      bad++;
      $display("FAIL mid_reset_edge: got %0d want 0", outp);
    end
    for (int i = 0; i < 8; i++) begin
      drive(in_v[i], o);
      total++;
      if (o !== exp_v[i]) begin
        bad++;
        $display("FAIL mid_reset[%0d]: got %0d want %0d", i, o, exp_v[i]);
      end
    end
  endtask

  // Reference sort: straightforward insertion sort on a 4-entry array.
  function automatic logic [4*DW-1:0] ref_sort(input logic [4*DW-1:0] f);
    logic [DW-1:0] a [4];
    logic [DW-1:0] t;
    logic [4*DW-1:0] r;
    for (int i = 0; i < 4; i++) a[i] = f[i*DW +: DW];
    for (int i = 1; i < 4; i++) begin
      for (int j = i; j > 0; j--) begin
        if (a[j] < a[j-1]) begin
          t = a[j];
          a[j] = a[j-1];
          a[j-1] = t;
        end
      end
    end
    for (int i = 0; i < 4; i++) r[i*DW +: DW] = a[i];
    return r;
  endfunction

  task automatic test_counter_stream();
    logic [DW-1:0]   o;
    logic [DW-1:0]   cnt;
    logic [4*DW-1:0] cur_frame;
    logic [4*DW-1:0] exp_frame;
    logic [DW-1:0]   e;
    cnt       = '0;
    cur_frame = '0;
    exp_frame = '0;
    do_reset();
    for (int c = 0; c < 80; c++) begin
      drive(cnt, o);
      e = exp_frame[(c % 4)*DW +: DW];
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL counter_stream[%0d]: got %0d want %0d", c, o, e);
      end
      cur_frame[(c % 4)*DW +: DW] = cnt;
      if (c % 4 == 3) exp_frame = ref_sort(cur_frame);
      if (c % 4 != 3) cnt = cnt + 3'd1;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    inp   = '0;
    test_reset();
    test_basic_sort();
    test_back_to_back();
    test_patterns();
    test_reset_mid_frame();
    test_counter_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
